// File: rtl/ps_bigreg_collector.sv
// Collects a run of memory-map words into one wide register and presents it
// to RTL consumers through valid/ready, answering each in-window write.
module ps_bigreg_collector #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 16,
    parameter int SAMPLES    = 16,
    parameter int BASE_ID    = 33
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [ID_WIDTH-1:0]           wr_id,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic [SAMPLES*DATA_WIDTH-1:0] reg_out,
    output logic                          reg_valid,
    input  logic                          reg_ready,
    output logic                          resp_valid,
    output logic [1:0]                    resp,
    output logic                          fresh_clr,
    output logic                          busy
);
    localparam int VALID_ID = BASE_ID + SAMPLES;
    localparam int IDX_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {ST_COLLECT, ST_HOLD} state_t;

    state_t                                 r_state;
    logic [SAMPLES-1:0][DATA_WIDTH-1:0]     r_staging;
    logic [SAMPLES-1:0]                     r_fresh;
    logic [SAMPLES*DATA_WIDTH-1:0]          r_reg_out;
    logic                                   r_reg_valid;
    logic                                   r_resp_valid;
    logic [1:0]                             r_resp;
    logic                                   r_fresh_clr;
    logic                                   r_busy;

    logic             w_data_wr;
    logic             w_valid_wr;
    logic [IDX_W-1:0] w_idx;
    logic             w_fresh_full;

    assign w_data_wr    = wr_en && (wr_id >= ID_WIDTH'(BASE_ID)) && (wr_id < ID_WIDTH'(VALID_ID));
    assign w_valid_wr   = wr_en && (wr_id == ID_WIDTH'(VALID_ID));
    // Offset is only meaningful once the range check has passed.
    assign w_idx        = IDX_W'(wr_id - ID_WIDTH'(BASE_ID));
    assign w_fresh_full = &r_fresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_COLLECT;
            r_staging    <= '0;
            r_fresh      <= '0;
            r_reg_out    <= '0;
            r_reg_valid  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp       <= RESP_OKAY;
            r_fresh_clr  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp       <= RESP_OKAY;
            r_fresh_clr  <= 1'b0;

            if (r_state == ST_HOLD && reg_ready) begin
                r_state     <= ST_COLLECT;
                r_reg_valid <= 1'b0;
                r_busy      <= 1'b0;
            end

            if (w_data_wr) begin
                r_staging[w_idx] <= wr_data;
                r_fresh[w_idx]   <= 1'b1;
                r_resp_valid     <= 1'b1;
                r_resp           <= RESP_OKAY;
            end else if (w_valid_wr) begin
                r_resp_valid <= 1'b1;
                // A HOLD-state valid write is refused even if the consumer
                // handshakes in the same cycle.
                if (r_state == ST_COLLECT && w_fresh_full) begin
                    r_reg_out   <= r_staging;
                    r_fresh     <= '0;
                    r_fresh_clr <= 1'b1;
                    r_state     <= ST_HOLD;
                    r_reg_valid <= 1'b1;
                    r_busy      <= 1'b1;
                    r_resp      <= RESP_OKAY;
                end else begin
                    r_resp      <= RESP_SLVERR;
                end
            end
        end
    end

    assign reg_out    = r_reg_out;
    assign reg_valid  = r_reg_valid;
    assign resp_valid = r_resp_valid;
    assign resp       = r_resp;
    assign fresh_clr  = r_fresh_clr;
    assign busy       = r_busy;
endmodule

// File: doc/ps_bigreg_collector.md
# ps_bigreg_collector

Assembles a wide PS-written register (PS_BIGREG) from a run of 16-bit memory-map words and hands it to RTL consumers through a valid/ready handshake. It sits directly downstream of the AXI memory-map write path, on the write-event stream (id, data, strobe). It watches one BASE_ID..BASE_ID+SAMPLES-1 window plus its VALID id, for example the sample-discriminator config at ids 33..48 with valid id 49. It returns a per-write response code and a fresh-clear pulse to the memory map.

## Interface
Parameters:
- ID_WIDTH, 8: width of memory-map index, $clog2(MEM_SIZE=256).
- DATA_WIDTH, 16: payload bits per memory-map word.
- SAMPLES, 16: words per big register; output width = SAMPLES*DATA_WIDTH (256).
- BASE_ID, 33: id of word 0; VALID_ID is fixed at BASE_ID+SAMPLES (49).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle strobe: memory-map write accepted this cycle.
- wr_id  in  ID_WIDTH  index being written.
- wr_data  in  DATA_WIDTH  word written (low 16 bits of the AXI data).
- reg_out  out  SAMPLES*DATA_WIDTH  assembled register; word k occupies bits [16k+15:16k].
- reg_valid  out  1  reg_out holds a new, complete value.
- reg_ready  in  1  consumer accepts reg_out.
- resp_valid  out  1  response for the previous-cycle in-window write.
- resp  out  2  OKAY=2'b00, SLVERR=2'b10.
- fresh_clr  out  1  one-cycle pulse: the memory map clears fresh bits for ids BASE_ID..VALID_ID.
- busy  out  1  high in HOLD.

## Operation
- Internal state: staging[SAMPLES] words, fresh[SAMPLES] bits, FSM {COLLECT, HOLD}.
- Data-word write (wr_en && BASE_ID <= wr_id < VALID_ID), accepted in either state:
  - staging[wr_id-BASE_ID] <= wr_data; fresh bit set.
  - Response OKAY.
  - A rewrite of an already fresh word overwrites it and still returns OKAY.
- Valid write (wr_en && wr_id == VALID_ID) in COLLECT with fresh all ones:
  - reg_out <= {staging[SAMPLES-1],...,staging[0]}.
  - fresh <= 0; staging keeps its contents.
  - fresh_clr pulses; FSM -> HOLD; response OKAY.
- Valid write in COLLECT with any fresh bit clear:
  - Response SLVERR; no state change; fresh bits are retained.
- Valid write in HOLD:
  - Response SLVERR; dropped.
  - Staging is untouched, so the PS may simply re-issue the valid write.
- Writes outside BASE_ID..VALID_ID are ignored: no response, no state change.
- HOLD:
  - reg_valid = 1; reg_out is stable.
  - When reg_valid && reg_ready, the FSM -> COLLECT on the next edge.
- Same-cycle handshake and valid write in HOLD: the write gets SLVERR, because the state during that cycle is HOLD.
- Same-cycle valid write and data write cannot occur (single write port).
- Index arithmetic: wr_id-BASE_ID is taken modulo $clog2(SAMPLES) bits, and only after the range check.

## Timing
- Reset (rst_n low, asynchronous): all of the following go to 0, and the FSM goes to COLLECT:
  - reg_out, reg_valid, resp_valid, resp, fresh_clr, busy.
  - staging and fresh.
- A mid-HOLD reset drops the pending value without a handshake.
- Write to response: resp_valid/resp are registered, 1 cycle after wr_en, high for exactly 1 cycle.
- Valid write to output: reg_valid, reg_out, fresh_clr and busy all update on the same edge, 1 cycle after the valid write.
- Handshake to next accept: reg_valid falls on the edge after the handshake cycle. A valid write in the cycle after that edge is accepted, so back-to-back register updates take at least 2 cycles.
- Data writes during HOLD land in staging without stalling and do not disturb reg_out.
- Back-to-back wr_en every cycle is supported, with one response per in-window write.

## Test plan
- Happy path:
  - Stimulus: write ids 33..48 with data 16'h0100+k, then valid id 49, with reg_ready held 1.
  - Required response: 17 OKAY responses; reg_valid for 1 cycle; reg_out[15:0]=16'h0100 and reg_out[255:240]=16'h010F; one fresh_clr pulse.
- Incomplete:
  - Stimulus: write ids 33..47 (skip 48), then id 49.
  - Required response: SLVERR, reg_valid stays 0.
  - Follow-up: write 48 = 16'hBEEF, then 49 -> OKAY, reg_out[255:240]=16'hBEEF.
- Backpressure:
  - Stimulus: complete register with reg_ready=0 for 5 cycles.
  - Required response: reg_valid and reg_out stable throughout.
  - Follow-up: new writes to 33..48 during this window return OKAY; a write to 49 returns SLVERR.
  - Stimulus: raise reg_ready, then re-write 49.
  - Required response: OKAY, and the new value is presented.
- Simultaneous:
  - Stimulus: in HOLD, assert reg_ready and write id 49 in the same cycle.
  - Required response: SLVERR; reg_valid=0 on the next edge.
- Out-of-window:
  - Stimulus: writes to ids 0, 32, 50 and 255.
  - Required response: no resp_valid, no state change.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously mid-collection (fresh=16'h00FF), and separately during HOLD.
  - Required response: all outputs 0 immediately; after release, a valid write returns SLVERR until all 16 words are rewritten.
